// File: rtl/mips_core_pkg.sv
// Shared types for the core's issue path: physical register index and the
// issue-queue entry layout.
package mips_core_pkg;

    localparam int unsigned PHYS_REG_W   = 6;
    localparam int unsigned IQ_PAYLOAD_W = 96;

    typedef logic [PHYS_REG_W-1:0] phys_reg_t;

    typedef struct packed {
        phys_reg_t               rs_phys;
        logic                    rs_rdy;
        phys_reg_t               rt_phys;
        logic                    rt_rdy;
        phys_reg_t               rw_phys;
        logic                    uses_rw;
        logic [IQ_PAYLOAD_W-1:0] payload;
    } iq_entry_t;

endpackage

// File: rtl/iq_select.sv
// Find-first-set over the per-slot ready vector; the lowest index wins,
// which is the oldest entry in the collapsing queue.
module iq_select #(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        // Scan downward so the final assignment is the lowest set bit.
        for (int unsigned i = N; i > 0; i--) begin
            if (req[i-1]) begin
                grant_idx = IDX_W'(i - 1);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Collapsing issue queue: oldest-ready select, wakeup by writeback broadcast,
// shift-down on issue, and full squash on flush.
module issue_scheduler
    import mips_core_pkg::*;
#(
    parameter int unsigned IQ_DEPTH  = 16,
    parameter int unsigned PREG_W    = PHYS_REG_W,
    parameter int unsigned PAYLOAD_W = IQ_PAYLOAD_W,
    parameter int unsigned CNT_W     = $clog2(IQ_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [PREG_W-1:0]    disp_rs_phys,
    input  logic                 disp_rs_rdy,
    input  logic [PREG_W-1:0]    disp_rt_phys,
    input  logic                 disp_rt_rdy,
    input  logic [PREG_W-1:0]    disp_rw_phys,
    input  logic                 disp_uses_rw,
    input  logic [PAYLOAD_W-1:0] disp_payload,
    input  logic                 wb_valid,
    input  logic [PREG_W-1:0]    wb_phys,
    input  logic                 issue_ready,
    output logic                 issue_valid,
    output logic [PREG_W-1:0]    issue_rw_phys,
    output logic                 issue_uses_rw,
    output logic [PREG_W-1:0]    issue_rs_phys,
    output logic [PREG_W-1:0]    issue_rt_phys,
    output logic [PAYLOAD_W-1:0] issue_payload,
    input  logic                 flush,
    output logic [CNT_W-1:0]     occupancy
);

    localparam int unsigned IDX_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;

    iq_entry_t          slots_q [IQ_DEPTH];
    iq_entry_t          slots_d [IQ_DEPTH];
    iq_entry_t          woken   [IQ_DEPTH];
    iq_entry_t          new_entry;
    iq_entry_t          sel;
    logic [CNT_W-1:0]   occ_q, occ_d, wr_idx;
    logic [IQ_DEPTH-1:0] req;
    logic [IDX_W-1:0]   grant_idx;
    logic               any_grant;
    logic               disp_fire, issue_fire;

    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
            req[i] = (CNT_W'(i) < occ_q) && slots_q[i].rs_rdy && slots_q[i].rt_rdy;
        end
    end

    iq_select #(.N(IQ_DEPTH), .IDX_W(IDX_W)) u_select (
        .req       (req),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        sel           = slots_q[grant_idx];
        disp_ready    = (occ_q < CNT_W'(IQ_DEPTH));
        issue_valid   = any_grant && !flush;
        issue_rw_phys = sel.rw_phys;
        issue_uses_rw = sel.uses_rw;
        issue_rs_phys = sel.rs_phys;
        issue_rt_phys = sel.rt_phys;
        issue_payload = sel.payload;
        occupancy     = occ_q;
        disp_fire     = disp_valid && disp_ready && !flush;
        issue_fire    = issue_valid && issue_ready;
    end

    always_comb begin
        new_entry.rs_phys = disp_rs_phys;
        new_entry.rs_rdy  = disp_rs_rdy || (wb_valid && (wb_phys == disp_rs_phys));
        new_entry.rt_phys = disp_rt_phys;
        new_entry.rt_rdy  = disp_rt_rdy || (wb_valid && (wb_phys == disp_rt_phys));
        new_entry.rw_phys = disp_rw_phys;
        new_entry.uses_rw = disp_uses_rw;
        new_entry.payload = disp_payload;
    end

    // Wakeup is applied to the pre-shift copy and then shifted, so every
    // entry carries its new ready bits into its post-shift position.
    always_comb begin
        for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
            woken[i] = slots_q[i];
            if (wb_valid && (slots_q[i].rs_phys == wb_phys)) woken[i].rs_rdy = 1'b1;
            if (wb_valid && (slots_q[i].rt_phys == wb_phys)) woken[i].rt_rdy = 1'b1;
        end
        for (int unsigned i = 0; i + 1 < IQ_DEPTH; i++) begin
            slots_d[i] = (issue_fire && (IDX_W'(i) >= grant_idx)) ? woken[i+1] : woken[i];
        end
        slots_d[IQ_DEPTH-1] = woken[IQ_DEPTH-1];
        wr_idx = occ_q - CNT_W'(issue_fire);
        for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
            if (disp_fire && (CNT_W'(i) == wr_idx)) slots_d[i] = new_entry;
        end
        occ_d = flush ? '0 : (occ_q + CNT_W'(disp_fire) - CNT_W'(issue_fire));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ_q <= '0;
        else        occ_q <= occ_d;
    end

    // Slot contents beyond occupancy are don't-care, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < IQ_DEPTH; i++) slots_q[i] <= slots_d[i];
    end

    occ_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        occ_q <= CNT_W'(IQ_DEPTH));
    occ_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(issue_fire && (occ_q == '0)));

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: ordering, wakeup timing, full queue,
// bypass, collapse on mid-queue issue, flush and asynchronous reset.
module tb_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_valid, disp_ready;
    logic [5:0]  disp_rs_phys, disp_rt_phys, disp_rw_phys;
    logic        disp_rs_rdy, disp_rt_rdy, disp_uses_rw;
    logic [95:0] disp_payload;
    logic        wb_valid;
    logic [5:0]  wb_phys;
    logic        issue_ready, issue_valid, issue_uses_rw;
    logic [5:0]  issue_rw_phys, issue_rs_phys, issue_rt_phys;
    logic [95:0] issue_payload;
    logic        flush;
    logic [4:0]  occupancy;

    int errors = 0;
    int checks = 0;

    issue_scheduler #(.IQ_DEPTH(16), .PREG_W(6), .PAYLOAD_W(96)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_rs_phys(disp_rs_phys), .disp_rs_rdy(disp_rs_rdy),
        .disp_rt_phys(disp_rt_phys), .disp_rt_rdy(disp_rt_rdy),
        .disp_rw_phys(disp_rw_phys), .disp_uses_rw(disp_uses_rw),
        .disp_payload(disp_payload),
        .wb_valid(wb_valid), .wb_phys(wb_phys),
        .issue_ready(issue_ready), .issue_valid(issue_valid),
        .issue_rw_phys(issue_rw_phys), .issue_uses_rw(issue_uses_rw),
        .issue_rs_phys(issue_rs_phys), .issue_rt_phys(issue_rt_phys),
        .issue_payload(issue_payload),
        .flush(flush), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        disp_valid = 1'b0; wb_valid = 1'b0; issue_ready = 1'b0; flush = 1'b0;
    endtask

    // rw_phys mirrors the low tag bits so the destination field is checked too.
    task automatic set_disp(input logic [5:0] rs, input logic rsr,
                            input logic [5:0] rt, input logic rtr, input logic [7:0] tag);
        disp_valid   = 1'b1;
        disp_rs_phys = rs;  disp_rs_rdy = rsr;
        disp_rt_phys = rt;  disp_rt_rdy = rtr;
        disp_rw_phys = tag[5:0];
        disp_uses_rw = 1'b1;
        disp_payload = {88'h0, tag};
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        set_disp(6'd0, 1'b1, 6'd0, 1'b1, 8'h00);
        disp_valid = 1'b0;
        wb_phys = '0;
        #2;
        chk("reset_occ", occupancy, 0);
        chk("reset_iv", issue_valid, 0);
        chk("reset_dr", disp_ready, 1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // In-order issue of three ready entries, issue_ready held high.
        issue_ready = 1'b1;
        set_disp(6'd1, 1'b1, 6'd2, 1'b1, 8'h01);
        tick();
        chk("t1_occ_a", occupancy, 1);
        chk("t1_pay_a", issue_payload, 8'h01);
        chk("t1_iv_a", issue_valid, 1);
        chk("t1_rw_a", issue_rw_phys, 6'h01);
        set_disp(6'd1, 1'b1, 6'd2, 1'b1, 8'h02);
        tick();
        chk("t1_occ_b", occupancy, 1);
        chk("t1_pay_b", issue_payload, 8'h02);
        set_disp(6'd1, 1'b1, 6'd2, 1'b1, 8'h03);
        tick();
        chk("t1_occ_c", occupancy, 1);
        chk("t1_pay_c", issue_payload, 8'h03);
        disp_valid = 1'b0;
        tick();
        chk("t1_occ_end", occupancy, 0);
        chk("t1_iv_end", issue_valid, 0);

        // Younger ready entry overtakes; wakeup is visible one cycle later.
        idle();
        set_disp(6'd10, 1'b0, 6'd0, 1'b1, 8'h0A);
        tick();
        set_disp(6'd11, 1'b1, 6'd12, 1'b1, 8'h0B);
        tick();
        disp_valid = 1'b0;
        chk("t2_occ", occupancy, 2);
        chk("t2_pay_b", issue_payload, 8'h0B);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("t2_occ_after_b", occupancy, 1);
        chk("t2_iv_a_blocked", issue_valid, 0);
        wb_valid = 1'b1; wb_phys = 6'd10;
        #1;
        chk("t2_no_same_cycle", issue_valid, 0);
        tick();
        wb_valid = 1'b0;
        chk("t2_iv_a_woken", issue_valid, 1);
        chk("t2_pay_a", issue_payload, 8'h0A);
        chk("t2_rs_a", issue_rs_phys, 6'd10);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("t2_occ_end", occupancy, 0);

        // Fill to capacity; a 17th dispatch is refused.
        for (int i = 0; i < 16; i++) begin
            set_disp(6'd30, 1'b0, 6'd0, 1'b1, 8'h10 + 8'(i));
            tick();
        end
        chk("t3_occ_full", occupancy, 16);
        chk("t3_dr_full", disp_ready, 0);
        chk("t3_iv_none", issue_valid, 0);
        set_disp(6'd0, 1'b1, 6'd0, 1'b1, 8'hFF);
        tick();
        disp_valid = 1'b0;
        chk("t3_occ_refused", occupancy, 16);
        wb_valid = 1'b1; wb_phys = 6'd30;
        tick();
        wb_valid = 1'b0;
        chk("t3_pay_head", issue_payload, 8'h10);
        issue_ready = 1'b1;
        #1;
        chk("t3_dr_no_lookahead", disp_ready, 0);
        tick();
        issue_ready = 1'b0;
        chk("t3_dr_after_issue", disp_ready, 1);
        chk("t3_occ_15", occupancy, 15);
        issue_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            chk("t3_drain_order", issue_payload, 8'h11 + 8'(i));
            tick();
        end
        issue_ready = 1'b0;
        chk("t3_occ_empty", occupancy, 0);
        chk("t3_iv_empty", issue_valid, 0);

        // Dispatch-time bypass of a matching writeback.
        set_disp(6'd3, 1'b1, 6'd7, 1'b0, 8'h44);
        wb_valid = 1'b1; wb_phys = 6'd7;
        tick();
        disp_valid = 1'b0; wb_valid = 1'b0;
        chk("t4_iv_bypass", issue_valid, 1);
        chk("t4_pay", issue_payload, 8'h44);
        chk("t4_rt", issue_rt_phys, 6'd7);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("t4_occ", occupancy, 0);

        // Issue from slot 2 of 5 with concurrent dispatch and wakeup of the
        // entries being shifted.
        set_disp(6'd40, 1'b0, 6'd0, 1'b1, 8'h50); tick();
        set_disp(6'd40, 1'b0, 6'd0, 1'b1, 8'h51); tick();
        set_disp(6'd1,  1'b1, 6'd0, 1'b1, 8'h52); tick();
        set_disp(6'd41, 1'b0, 6'd0, 1'b1, 8'h53); tick();
        set_disp(6'd41, 1'b0, 6'd0, 1'b1, 8'h54); tick();
        chk("t5_occ5", occupancy, 5);
        chk("t5_pay_slot2", issue_payload, 8'h52);
        set_disp(6'd2, 1'b1, 6'd0, 1'b1, 8'h55);
        issue_ready = 1'b1;
        wb_valid = 1'b1; wb_phys = 6'd41;
        tick();
        disp_valid = 1'b0; issue_ready = 1'b0; wb_valid = 1'b0;
        chk("t5_occ_same", occupancy, 5);
        chk("t5_pay_shifted", issue_payload, 8'h53);
        wb_valid = 1'b1; wb_phys = 6'd40;
        tick();
        wb_valid = 1'b0;
        issue_ready = 1'b1;
        chk("t5_order0", issue_payload, 8'h50); tick();
        chk("t5_order1", issue_payload, 8'h51); tick();
        chk("t5_order2", issue_payload, 8'h53); tick();
        chk("t5_order3", issue_payload, 8'h54); tick();
        chk("t5_order4", issue_payload, 8'h55); tick();
        issue_ready = 1'b0;
        chk("t5_occ_end", occupancy, 0);

        // Flush at occupancy 9 with concurrent dispatch, wakeup and issue.
        set_disp(6'd1, 1'b1, 6'd0, 1'b1, 8'h60);
        tick();
        for (int i = 1; i < 9; i++) begin
            set_disp(6'd50, 1'b0, 6'd0, 1'b1, 8'h60 + 8'(i));
            tick();
        end
        chk("t6_occ9", occupancy, 9);
        chk("t6_iv_pre", issue_valid, 1);
        set_disp(6'd0, 1'b1, 6'd0, 1'b1, 8'h77);
        wb_valid = 1'b1; wb_phys = 6'd50;
        issue_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("t6_iv_during_flush", issue_valid, 0);
        tick();
        idle();
        chk("t6_occ0", occupancy, 0);
        chk("t6_iv0", issue_valid, 0);
        chk("t6_dr", disp_ready, 1);

        // Asynchronous reset mid-operation.
        set_disp(6'd1, 1'b1, 6'd0, 1'b1, 8'h88); tick();
        set_disp(6'd1, 1'b1, 6'd0, 1'b1, 8'h89); tick();
        disp_valid = 1'b0;
        chk("t7_occ2", occupancy, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_occ", occupancy, 0);
        chk("t7_rst_iv", issue_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t7_after_occ", occupancy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Collapsing issue queue between register renaming and the ALU stage.
- Accepts renamed instructions and tracks source-operand readiness through writeback wakeup broadcasts.
- Each cycle, hands the oldest ready instruction to the ALU with a valid/ready handshake.
- Discards all contents on a hazard-controller flush.

Parameters:
- IQ_DEPTH, 16, number of queue slots.
- PREG_W, 6, physical register index width (64 physical regs).
- PAYLOAD_W, 96, opaque per-instruction payload (alu_ctl, immediate, branch/mem fields), passed through untouched.
- CNT_W, $clog2(IQ_DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- disp_valid  in  1  rename stage presents an instruction
- disp_ready  out  1  queue can accept (occupancy < IQ_DEPTH)
- disp_rs_phys  in  PREG_W  source 1 physical reg
- disp_rs_rdy  in  1  source 1 ready at rename (1 when rs unused)
- disp_rt_phys  in  PREG_W  source 2 physical reg
- disp_rt_rdy  in  1  source 2 ready at rename (1 when rt unused)
- disp_rw_phys  in  PREG_W  destination physical reg
- disp_uses_rw  in  1  destination valid
- disp_payload  in  PAYLOAD_W  pass-through fields
- wb_valid  in  1  writeback broadcast valid
- wb_phys  in  PREG_W  physical reg being written back
- issue_ready  in  1  ALU stage can accept
- issue_valid  out  1  an entry is selected for issue
- issue_rw_phys  out  PREG_W  selected entry destination
- issue_uses_rw  out  1  selected entry destination valid
- issue_rs_phys  out  PREG_W  selected entry source 1
- issue_rt_phys  out  PREG_W  selected entry source 2
- issue_payload  out  PAYLOAD_W  selected entry payload
- flush  in  1  squash all entries (from hazard controller)
- occupancy  out  CNT_W  current valid entries

Behaviour:
- Reset (async, rst_n low): all slot valid bits 0, occupancy 0, issue_valid 0, disp_ready 1. Slot contents are don't-care.
- Storage and ordering:
  - Slots 0..occupancy-1 are valid. Slot 0 is the oldest; no holes are allowed.
  - Entry fields: rs_phys, rs_rdy, rt_phys, rt_rdy, rw_phys, uses_rw, payload.
- Dispatch:
  - Accepted at the posedge where disp_valid && disp_ready.
  - disp_ready = (occupancy < IQ_DEPTH), from registered occupancy only. There is no issue lookahead, so a full queue refuses dispatch even in a cycle where an issue occurs.
- Wakeup:
  - At the posedge with wb_valid, every valid entry with rs_phys==wb_phys sets rs_rdy; likewise for rt.
  - Bypass: an instruction dispatched in the same cycle whose source matches wb_phys is written with that rdy bit set.
- Select (combinational):
  - Picks the lowest-index slot with valid && rs_rdy && rt_rdy.
  - issue_valid = any such slot; issue_* outputs reflect that slot.
  - An entry woken at edge N is first selectable in cycle N+1. There is no same-cycle wakeup-to-issue.
- Issue handshake:
  - On a posedge with issue_valid && issue_ready, the selected slot k is removed.
  - Slots k+1..occupancy-1 shift down by one; occupancy decrements.
  - While issue_ready is low, outputs are held, subject to a newly woken older entry taking priority on the next cycle.
- Simultaneous dispatch and issue: shift first, then the new entry is written at index occupancy-1; occupancy is unchanged. The new entry is never issued in its dispatch cycle.
- Simultaneous wakeup and shift: rdy updates apply to entries at their post-shift positions; no wakeup is lost.
- Flush:
  - At the posedge with flush, all valid bits clear and occupancy becomes 0.
  - Dispatch, issue and wakeup in that cycle are ignored.
  - issue_valid reads 0 combinationally while flush is high.
- Occupancy arithmetic: next = occupancy + dispatch_fire - issue_fire. It never exceeds IQ_DEPTH and never underflows; assertions check both.
- Reset mid-operation: all state clears immediately; no partial issue is observable.

Decomposition:
- Shared package (mips_core_pkg):
  - PHYS_REG_W=6.
  - typedef iq_entry_t (fields above).
  - typedef phys_reg_t.
- Sub-module iq_select: parameterised find-first-set over IQ_DEPTH ready bits. Outputs grant index and any_grant.

Test Plan:
- Reset, then dispatch 3 entries with both sources rdy, issue_ready=1 -> issues in dispatch order on cycles 1,2,3; occupancy 0 after the third.
- Dispatch A (rs=p10 not ready), then B (ready) -> B issues first. Then wb_valid with wb_phys=10 at edge N -> A issue_valid at cycle N+1, not N.
- Fill 16 entries with none ready -> disp_ready=0 and a 17th disp_valid is not accepted. One wakeup, issue at edge M -> disp_ready=1 in cycle M+1.
- Dispatch entry with rt=p7 in the same cycle as wb_valid, wb_phys=7 -> entry stored rt_rdy=1 and issues the next cycle.
- Issue slot 2 of 5 with a simultaneous dispatch -> old slots 3,4 move to 2,3; new entry lands at slot 4; occupancy stays 5.
- Occupancy 9 with flush=1 plus concurrent disp_valid and wb_valid -> occupancy 0, issue_valid 0 next cycle, and the dispatched instruction is absent.
